led_frame_arbiter: RTL and testbench

Shares the SK9822 LED frame RAM between two writers: the CPU bus path (req0) and the DSP level-meter engine (req1). Each accepted write goes to the RAM write port. The RAM is split into two banks (double-buffered), and a commit handshake swaps the display bank only at an LED frame boundary, so a frame never tears. The block sits between the two requesters and the LED peripheral's RAM write port and its read-bank select.

---
 rtl/led_frame_arbiter.sv | 153 +++++++++++++++
 tb/tb_led_frame_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_arbiter.sv
// -----------------------------------------------------------------------------
// led_frame_arbiter
//
// Shares the double-buffered SK9822 LED frame RAM between the CPU bus writer
// (req0) and the DSP level-meter engine (req1). Accepted writes are registered
// onto the RAM write port, tagged with the current write bank. A commit
// request swaps the write and display banks, but only at the next LED frame
// boundary (frame_sync). This keeps the LED engine from showing a half-written
// frame.
//
// Ports:
//   wb_clk, wb_rst_n        clock, async active-low reset
//   req0_* / req1_*         valid/ready write requesters (addr, 32-bit data)
//   commit                  pulse: present the write bank at next frame_sync
//   frame_sync              pulse: LED engine is starting a frame
//   bright_max              brightness ceiling (LED_ARB_BRIGHT_EN builds only)
//   led_we/led_addr/led_data  registered RAM write port, addr = {bank, word}
//   disp_bank               bank currently read by the LED engine
//   pending                 a commit is waiting for frame_sync
//   commit_done             one-cycle pulse when the banks swap
//
// Build option: define LED_ARB_BRIGHT_EN to clamp the SK9822 global brightness
// field (data[28:24]) to bright_max and force the header bits [31:29] to 3'b111.
// -----------------------------------------------------------------------------
module led_frame_arbiter #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 req0_valid,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [31:0]          req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [31:0]          req1_data,
    output logic                 req1_ready,
    input  logic                 commit,
    input  logic                 frame_sync,
    input  logic [4:0]           bright_max,
    output logic                 led_we,
    output logic [ADDR_BITS:0]   led_addr,
    output logic [31:0]          led_data,
    output logic                 disp_bank,
    output logic                 pending,
    output logic                 commit_done
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t               state_q, state_d;
    logic                 write_bank_q, write_bank_d;
    logic                 disp_bank_q, disp_bank_d;
    logic                 last_grant_q, last_grant_d;
    logic                 commit_done_q, commit_done_d;
    logic                 led_we_q, led_we_d;
    logic [ADDR_BITS:0]   led_addr_q, led_addr_d;
    logic [31:0]          led_data_q, led_data_d;

`ifdef LED_ARB_BRIGHT_EN
    function automatic logic [31:0] shape_data(input logic [31:0] d, input logic [4:0] bmax);
        logic [4:0] b;
        b = (d[28:24] > bmax) ? bmax : d[28:24];
        return {3'b111, b, d[23:0]};
    endfunction
`else
    // Pass-through build: bright_max has no function here.
    logic bright_unused;
    assign bright_unused = ^bright_max;

    function automatic logic [31:0] shape_data(input logic [31:0] d, input logic [4:0] bmax);
        logic [4:0] unused_bmax;
        unused_bmax = bmax;
        return d;
    endfunction
`endif

    always_comb begin
        state_d       = state_q;
        write_bank_d  = write_bank_q;
        disp_bank_d   = disp_bank_q;
        last_grant_d  = last_grant_q;
        commit_done_d = 1'b0;
        led_we_d      = 1'b0;
        led_addr_d    = led_addr_q;
        led_data_d    = led_data_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                // Round-robin: on contention the side not granted last wins.
                req0_ready = req0_valid && (!req1_valid || last_grant_q);
                req1_ready = req1_valid && (!req0_valid || !last_grant_q);
                // A frame_sync arriving with commit is too early; wait for the next one.
                if (commit) state_d = PENDING;
            end
            PENDING: begin
                if (frame_sync) begin
                    disp_bank_d   = write_bank_q;
                    write_bank_d  = ~write_bank_q;
                    commit_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bank bit is taken from the current write bank, so a write accepted
        // alongside commit still lands in the bank being committed.
        if (req0_ready) begin
            led_we_d     = 1'b1;
            led_addr_d   = {write_bank_q, req0_addr};
            led_data_d   = shape_data(req0_data, bright_max);
            last_grant_d = 1'b0;
        end else if (req1_ready) begin
            led_we_d     = 1'b1;
            led_addr_d   = {write_bank_q, req1_addr};
            led_data_d   = shape_data(req1_data, bright_max);
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q       <= IDLE;
            write_bank_q  <= 1'b1;
            disp_bank_q   <= 1'b0;
            last_grant_q  <= 1'b1;
            commit_done_q <= 1'b0;
            led_we_q      <= 1'b0;
            led_addr_q    <= '0;
            led_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            write_bank_q  <= write_bank_d;
            disp_bank_q   <= disp_bank_d;
            last_grant_q  <= last_grant_d;
            commit_done_q <= commit_done_d;
            led_we_q      <= led_we_d;
            led_addr_q    <= led_addr_d;
            led_data_q    <= led_data_d;
        end
    end

    assign led_we      = led_we_q;
    assign led_addr    = led_addr_q;
    assign led_data    = led_data_q;
    assign disp_bank   = disp_bank_q;
    assign pending     = (state_q == PENDING);
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_frame_arbiter
//
// Directed bench for led_frame_arbiter: reset values, single write, round-robin
// contention, commit/frame_sync swap timing, commit+frame_sync coincidence,
// async reset during a pending commit, and brightness shaping.
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked right after that, combinational readies 1 unit later.
// -----------------------------------------------------------------------------
module tb_led_frame_arbiter;

    localparam int AB = 4;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic          req0_valid, req1_valid;
    logic [AB-1:0] req0_addr, req1_addr;
    logic [31:0]   req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          commit, frame_sync;
    logic [4:0]    bright_max;
    logic          led_we;
    logic [AB:0]   led_addr;
    logic [31:0]   led_data;
    logic          disp_bank, pending, commit_done;

    int n_chk = 0;
    int n_err = 0;

    led_frame_arbiter #(.ADDR_BITS(AB)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .commit      (commit),
        .frame_sync  (frame_sync),
        .bright_max  (bright_max),
        .led_we      (led_we),
        .led_addr    (led_addr),
        .led_data    (led_data),
        .disp_bank   (disp_bank),
        .pending     (pending),
        .commit_done (commit_done)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        commit = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        idle_inputs();
        #13;
        wb_rst_n = 1'b1;
        step();
    endtask

    int i0, i1;
    logic exp0;
    logic [31:0] exp_data;
    logic [31:0] raw0, raw1, shaped0, shaped1;

    initial begin
        bright_max = 5'd4;
        wb_rst_n   = 1'b0;
        idle_inputs();

        // ---- reset values ----
        #3;
        chk("rst_led_we", {31'd0, led_we}, 32'd0);
        chk("rst_led_addr", {27'd0, led_addr}, 32'd0);
        chk("rst_led_data", led_data, 32'd0);
        chk("rst_disp_bank", {31'd0, disp_bank}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_commit_done", {31'd0, commit_done}, 32'd0);
        #10;
        wb_rst_n = 1'b1;
        step();

        // ---- single write lands in write bank 1 ----
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'hE100FF00;
        #1;
        chk("w1_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("w1_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        chk("w1_led_we", {31'd0, led_we}, 32'd1);
        chk("w1_led_addr", {27'd0, led_addr}, 32'h13);
        chk("w1_led_data", led_data, 32'hE100FF00);
        chk("w1_disp_bank", {31'd0, disp_bank}, 32'd0);
        step();
        chk("w1_led_we_drop", {31'd0, led_we}, 32'd0);

        // ---- contention after fresh reset: 0,1,0,1,0,1 ----
        do_reset();
        i0 = 0; i1 = 0;
        for (int c = 0; c < 6; c++) begin
            req0_valid = 1'b1; req0_addr = 4'(i0);     req0_data = 32'hA0000000 | 32'(i0);
            req1_valid = 1'b1; req1_addr = 4'(8 + i1); req1_data = 32'hB0000000 | 32'(i1);
            exp0 = (c % 2 == 0);
            exp_data = exp0 ? (32'hA0000000 | 32'(i0)) : (32'hB0000000 | 32'(i1));
            #1;
            chk($sformatf("rr%0d_req0_ready", c), {31'd0, req0_ready}, {31'd0, exp0});
            chk($sformatf("rr%0d_req1_ready", c), {31'd0, req1_ready}, {31'd0, !exp0});
            step();
            chk($sformatf("rr%0d_led_we", c), {31'd0, led_we}, 32'd1);
            chk($sformatf("rr%0d_led_data", c), led_data, exp_data);
            if (exp0) i0++; else i1++;
        end
        idle_inputs();
        chk("rr_count0", 32'(i0), 32'd3);
        chk("rr_count1", 32'(i1), 32'd3);
        step();
        chk("rr_led_we_drop", {31'd0, led_we}, 32'd0);

        // ---- commit at t, frame_sync at t+5 ----
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("cm_t%0d_pending", k), {31'd0, pending}, 32'd1);
            req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'h00000011;
            #1;
            chk($sformatf("cm_t%0d_ready", k), {31'd0, req0_ready}, 32'd0);
            chk($sformatf("cm_t%0d_disp", k), {31'd0, disp_bank}, 32'd0);
            if (k == 5) frame_sync = 1'b1;
            step();
        end
        frame_sync = 1'b0;
        chk("cm_t6_commit_done", {31'd0, commit_done}, 32'd1);
        chk("cm_t6_disp_bank", {31'd0, disp_bank}, 32'd1);
        chk("cm_t6_pending", {31'd0, pending}, 32'd0);
        #1;
        chk("cm_t6_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("cm_wr_led_we", {31'd0, led_we}, 32'd1);
        chk("cm_wr_led_addr", {27'd0, led_addr}, 32'h05);
        chk("cm_commit_done_drop", {31'd0, commit_done}, 32'd0);

        // ---- commit with frame_sync same cycle: no swap yet ----
        commit = 1'b1; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("cf_pending", {31'd0, pending}, 32'd1);
        chk("cf_disp_held", {31'd0, disp_bank}, 32'd1);
        chk("cf_no_done", {31'd0, commit_done}, 32'd0);
        step();  // commit still high: ignored while pending
        commit = 1'b0;
        chk("cf_pending2", {31'd0, pending}, 32'd1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("cf_done", {31'd0, commit_done}, 32'd1);
        chk("cf_disp_swapped", {31'd0, disp_bank}, 32'd0);
        chk("cf_pending_clr", {31'd0, pending}, 32'd0);
        step();
        chk("cf_no_extra_pending", {31'd0, pending}, 32'd0);
        chk("cf_no_extra_done", {31'd0, commit_done}, 32'd0);

        // ---- async reset while pending, with a write in flight ----
        // State now: disp_bank 0, write_bank 1. Swap once more so disp_bank=1.
        commit = 1'b1;
        step();
        commit = 1'b0; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("ar_pre_disp", {31'd0, disp_bank}, 32'd1);
        commit = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 32'h12345678;
        step();
        idle_inputs();
        chk("ar_led_we_inflight", {31'd0, led_we}, 32'd1);
        chk("ar_pending_set", {31'd0, pending}, 32'd1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("ar_led_we", {31'd0, led_we}, 32'd0);
        chk("ar_led_addr", {27'd0, led_addr}, 32'd0);
        chk("ar_led_data", led_data, 32'd0);
        chk("ar_pending", {31'd0, pending}, 32'd0);
        chk("ar_disp_bank", {31'd0, disp_bank}, 32'd0);
        chk("ar_commit_done", {31'd0, commit_done}, 32'd0);
        #3;
        wb_rst_n = 1'b1;
        step();
        chk("ar_post_we1", {31'd0, led_we}, 32'd0);
        step();
        chk("ar_post_we2", {31'd0, led_we}, 32'd0);
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h0;
        step();
        req0_valid = 1'b0;
        chk("ar_bank_restored", {27'd0, led_addr}, 32'h11);

        // ---- brightness shaping (or pass-through) ----
        raw0 = 32'hFF123456;
        raw1 = 32'hE2ABCDEF;
`ifdef LED_ARB_BRIGHT_EN
        shaped0 = 32'hE4123456;
        shaped1 = 32'hE2ABCDEF;
`else
        shaped0 = 32'hFF123456;
        shaped1 = 32'hE2ABCDEF;
`endif
        req0_valid = 1'b1; req0_addr = 4'd0; req0_data = raw0;
        step();
        chk("br_data0", led_data, shaped0);
        req0_data = raw1;
        step();
        req0_valid = 1'b0;
        chk("br_data1", led_data, shaped1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
